// File: rtl/mem_pkg.sv
// Shared constants and types for the 16-bit memory slave and its bench.
package mem_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

   localparam data_t DATA_Z = 'z;
endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W word storage with one synchronous write port, one combinational
// read port, and a per-word written-valid bit that reset clears.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic             rvalid_o
);

   data_t            mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   // NOTE: the storage array has no reset; the valid bits below mask stale words instead.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   assign rdata_o  = mem_q[idx_i];
   assign rvalid_o = valid_q[idx_i];

endmodule

// File: rtl/mem_modport_ram.sv
// Single-port RAM slave on a shared tristate data bus: decodes rd/wr, range-checks
// the address, registers read data, and drives the bus only during reads.
module mem_modport_ram
   import mem_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   inout  wire  [DATA_W-1:0] data
);

   localparam int    IDX_W   = $clog2(DEPTH);
   localparam addr_t DEPTH_A = addr_t'(DEPTH);

   logic             in_range;
   logic             we;
   logic [IDX_W-1:0] idx;
   data_t            arr_rdata;
   logic             arr_rvalid;

   logic  rd_d, rd_q;
   data_t rd_data_d, rd_data_q;

   assign idx = addr[IDX_W-1:0];

   // NOTE: every signal gets a default before any branch so no latch is inferred.
   // If/else rather than ?: so an unknown address falls to the no-write / zero-data branch.
   always_comb begin
      in_range  = 1'b0;
      we        = 1'b0;
      rd_d      = 1'b0;
      rd_data_d = rd_data_q;
      if (addr < DEPTH_A) begin
         in_range = 1'b1;
      end
      if (wr && in_range) begin
         we = 1'b1;
      end
      if (rd && !wr) begin
         rd_d = 1'b1;
         if (in_range && arr_rvalid) begin
            rd_data_d = arr_rdata;
         end else begin
            rd_data_d = '0;
         end
      end
   end

   mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .we_i     (we),
      .idx_i    (idx),
      .wdata_i  (data),
      .rdata_o  (arr_rdata),
      .rvalid_o (arr_rvalid)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q      <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_q      <= rd_d;
         rd_data_q <= rd_data_d;
      end
   end

   // The RAM never drives while wr is high, so the tester's write driver never collides.
   assign data = (rd_q && rd && !wr) ? rd_data_q : DATA_Z;

endmodule

// File: tb/tb_mem_modport_ram.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic compared every cycle against a word-level model of the RAM.
module tb_mem_modport_ram;
   import mem_pkg::*;

   localparam int    DEPTH    = 1024;
   // A pull-up on the shared bus makes a released bus read as all ones.
   localparam data_t BUS_IDLE = 16'hFFFF;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   addr_t addr = '0;
   logic  rd = 1'b0;
   logic  wr = 1'b0;
   logic  tb_oe = 1'b0;
   data_t tb_drv = '0;
   wire [DATA_W-1:0] data;

   int n_cmp  = 0;
   int n_fail = 0;

   assign data = tb_oe ? tb_drv : DATA_Z;
   pullup (data);

   always #10 clk = ~clk;

   mem_modport_ram #(
      .DEPTH (DEPTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .rd   (rd),
      .wr   (wr),
      .data (data)
   );

   // Word-level model: what was written where, and the result of the last accepted read.
   data_t m_mem [DEPTH];
   bit    m_wr  [DEPTH];
   bit    m_last_rd  = 1'b0;
   data_t m_last_val = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_last_rd <= 1'b0;
         foreach (m_wr[i]) m_wr[i] <= 1'b0;
      end else if (wr) begin
         if (int'(addr) < DEPTH) begin
            m_mem[int'(addr)] <= tb_drv;
            m_wr[int'(addr)]  <= 1'b1;
         end
         m_last_rd <= 1'b0;
      end else if (rd) begin
         m_last_rd  <= 1'b1;
         m_last_val <= (int'(addr) < DEPTH && m_wr[int'(addr)]) ? m_mem[int'(addr)] : 16'h0000;
      end else begin
         m_last_rd <= 1'b0;
      end
   end

   task automatic check(input string name, input data_t act, input data_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: bus=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Compare process: while the tester is not driving, the bus must match the model.
   always @(negedge clk) begin
      if (!wr) begin
         if (m_last_rd && rd) check("cycle_read", data, m_last_val);
         else                 check("cycle_idle", data, BUS_IDLE);
      end
   end

   task automatic set_in(input addr_t a, input logic r, input logic w, input data_t d);
      addr   = a;
      rd     = r;
      wr     = w;
      tb_oe  = w;
      tb_drv = d;
   endtask

   // Inputs change 2 units after a rising edge, well away from both clock edges.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic write_word(input addr_t a, input data_t d);
      set_in(a, 1'b0, 1'b1, d);
      step();
   endtask

   task automatic read_word(input string name, input addr_t a, input data_t exp);
      set_in(a, 1'b1, 1'b0, '0);
      step();
      check(name, data, exp);
   endtask

   initial begin
      #1 rst = 1'b1;
      #4 check("bus_in_reset", data, BUS_IDLE);
      step();
      rst = 1'b0;
      step();
      step();
      check("bus_after_reset", data, BUS_IDLE);

      write_word(16'h0005, 16'hA5A5);
      read_word("rd_5", 16'h0005, 16'hA5A5);
      read_word("rd_unwritten", 16'h0010, 16'h0000);
      set_in(16'h0000, 1'b0, 1'b0, '0);
      #1 check("release_same_cycle", data, BUS_IDLE);
      step();

      // Write and read together: write wins, no read result follows.
      set_in(16'h0003, 1'b1, 1'b1, 16'h1234);
      step();
      set_in(16'h0003, 1'b1, 1'b0, '0);
      #1 check("no_drive_after_wr_rd", data, BUS_IDLE);
      step();
      check("rd_3_after_wr_rd", data, 16'h1234);

      for (int i = 0; i < 4; i++) write_word(addr_t'(i), data_t'(i));
      for (int i = 0; i < 4; i++) read_word($sformatf("b2b_%0d", i), addr_t'(i), data_t'(i));

      write_word(16'h0000, 16'h0BAD);
      write_word(16'h8000, 16'hFFFF);
      read_word("rd_out_of_range", 16'h8000, 16'h0000);
      read_word("alias_untouched", 16'h0000, 16'h0BAD);
      write_word(16'h0400, 16'hFFFF);
      read_word("alias_400_untouched", 16'h0000, 16'h0BAD);

      // Reset in the middle of a read: bus releases at once, written state is forgotten.
      write_word(16'h0007, 16'h7777);
      read_word("rd_7_before_rst", 16'h0007, 16'h7777);
      #3 rst = 1'b1;
      #1 check("rst_mid_read", data, BUS_IDLE);
      step();
      rst = 1'b0;
      step();
      check("rd_7_after_rst", data, 16'h0000);
      set_in(16'h0000, 1'b0, 1'b0, '0);
      step();

      for (int n = 0; n < 400; n++) begin
         addr_t a;
         data_t d;
         int    op;
         case ($urandom_range(0, 3))
            0, 1:    a = addr_t'($urandom_range(0, 15));
            2:       a = addr_t'(16'h0400 + $urandom_range(0, 15));
            default: a = addr_t'($urandom_range(0, 16'hFFFF));
         endcase
         d  = data_t'($urandom_range(0, 16'hFFFE));
         op = $urandom_range(0, 9);
         if (op < 4)       set_in(a, 1'b1, 1'b0, '0);
         else if (op < 7)  set_in(a, 1'b0, 1'b1, d);
         else if (op < 8)  set_in(a, 1'b1, 1'b1, d);
         else              set_in(a, 1'b0, 1'b0, '0);
         step();
      end

      set_in(16'h0000, 1'b0, 1'b0, '0);
      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
